// File: rtl/bus_width_adapter_pkg.sv
// Shared types and parameter legality helpers for the wide-to-narrow bus adapter.
// The adapter top instantiates these at elaboration time only.
package bus_width_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BEATS = 2'd1,
        RD_BEATS = 2'd2,
        RESP     = 2'd3
    } state_t;

    function automatic bit width_ok(input int proc_dw, input int mem_dw);
        return (mem_dw >= 8) && (mem_dw % 8 == 0) && (proc_dw >= mem_dw) && (proc_dw % mem_dw == 0);
    endfunction

    function automatic bit ratio_ok(input int r);
        return (r >= 1) && (r <= 16) && ((r & (r - 1)) == 0);
    endfunction

    function automatic bit ports_ok(input int n);
        return (n >= 1) && (n <= 8);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest-index requester at or after ptr, wrapping.
// Produces a one-hot grant plus its binary index.
module rr_arbiter #(
    parameter int N_PORTS = 2,
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [N_PORTS-1:0] grant,
    output logic [PW-1:0]      grant_idx,
    output logic               grant_valid
);

    int idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int i = 0; i < N_PORTS; i++) begin
            idx = (int'(ptr) + i) % N_PORTS;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_width_adapter.sv
// Arbitrates N_PORTS wide processor ports onto one narrow memory port, splitting
// writes into R beats and gathering R read beats into one wide response.
module bus_width_adapter
    import bus_width_adapter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int PROC_DW = 64,
    parameter int MEM_DW  = 16,
    parameter int N_PORTS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_PORTS-1:0]         p_req_valid,
    output logic [N_PORTS-1:0]         p_req_ready,
    input  logic [N_PORTS-1:0]         p_req_we,
    input  logic [N_PORTS*ADDR_W-1:0]  p_req_addr,
    input  logic [N_PORTS*PROC_DW-1:0] p_req_wdata,
    output logic [N_PORTS-1:0]         p_rsp_valid,
    output logic [PROC_DW-1:0]         p_rsp_rdata,
    output logic                       m_req_valid,
    input  logic                       m_req_ready,
    output logic                       m_req_we,
    output logic [ADDR_W-1:0]          m_req_addr,
    output logic [MEM_DW-1:0]          m_req_wdata,
    input  logic                       m_rsp_valid,
    input  logic [MEM_DW-1:0]          m_rsp_rdata,
    output logic                       err
);

    localparam int R          = PROC_DW / MEM_DW;
    localparam int BEAT_BYTES = MEM_DW / 8;
    localparam int ALIGN_BITS = $clog2(PROC_DW / 8);
    localparam int PW         = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CW         = $clog2(R + 1);
    localparam logic [CW-1:0]     LAST_BEAT  = CW'(R - 1);
    localparam logic [CW-1:0]     ISSUE_END  = CW'(R);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

    if (!width_ok(PROC_DW, MEM_DW)) begin : g_bad_width
        $error("bus_width_adapter: PROC_DW must be a multiple of MEM_DW, MEM_DW a multiple of 8");
    end
    if (!ratio_ok(PROC_DW / MEM_DW)) begin : g_bad_ratio
        $error("bus_width_adapter: PROC_DW/MEM_DW must be a power of two in 1..16");
    end
    if (!ports_ok(N_PORTS)) begin : g_bad_ports
        $error("bus_width_adapter: N_PORTS must be in 1..8");
    end

    state_t               state, state_nx;
    logic [PW-1:0]        rr_ptr, port_q, grant_idx;
    logic [N_PORTS-1:0]   grant;
    logic                 grant_valid;
    logic                 we_q;
    logic [ADDR_W-1:0]    base_q;
    logic [PROC_DW-1:0]   wdata_q, asm_q;
    logic [CW-1:0]        issue_cnt, ret_cnt;
    logic                 req_fire, issuing, beat_fire, rsp_expected, rsp_take;

    rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
        .req         (p_req_valid),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_fire  = (state == IDLE) && grant_valid;
    assign issuing   = ((state == WR_BEATS) || (state == RD_BEATS)) && (issue_cnt != ISSUE_END);
    assign beat_fire = issuing && m_req_ready;
    // A return may land in the same cycle its beat is accepted, so count that beat as outstanding.
    assign rsp_expected = (state == RD_BEATS) && ((ret_cnt < issue_cnt) || beat_fire);
    assign rsp_take     = m_rsp_valid && rsp_expected;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        p_req_ready = '0;
        p_rsp_valid = '0;
        p_rsp_rdata = '0;
        m_req_valid = 1'b0;
        m_req_we    = 1'b0;
        m_req_addr  = '0;
        m_req_wdata = '0;
        case (state)
            IDLE: begin
                if (rst_n) p_req_ready = grant;
                if (req_fire) state_nx = p_req_we[grant_idx] ? WR_BEATS : RD_BEATS;
            end
            WR_BEATS, RD_BEATS: begin
                m_req_valid = issuing;
                m_req_we    = issuing && we_q;
                if (issuing) begin
                    m_req_addr = base_q + ADDR_W'(issue_cnt) * ADDR_W'(BEAT_BYTES);
                    if (we_q) m_req_wdata = wdata_q[int'(issue_cnt)*MEM_DW +: MEM_DW];
                end
                if (state == WR_BEATS && beat_fire && issue_cnt == LAST_BEAT) state_nx = RESP;
                if (state == RD_BEATS && rsp_take && ret_cnt == LAST_BEAT)    state_nx = RESP;
            end
            RESP: begin
                p_rsp_valid = N_PORTS'(1) << port_q;
                if (!we_q) p_rsp_rdata = asm_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            port_q    <= '0;
            we_q      <= 1'b0;
            base_q    <= '0;
            wdata_q   <= '0;
            asm_q     <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            if (req_fire) begin
                port_q    <= grant_idx;
                we_q      <= p_req_we[grant_idx];
                base_q    <= p_req_addr[int'(grant_idx)*ADDR_W +: ADDR_W] & ALIGN_MASK;
                wdata_q   <= p_req_wdata[int'(grant_idx)*PROC_DW +: PROC_DW];
                rr_ptr    <= (int'(grant_idx) == N_PORTS - 1) ? '0 : grant_idx + 1'b1;
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end else begin
                if (beat_fire) issue_cnt <= issue_cnt + 1'b1;
                if (rsp_take) begin
                    ret_cnt <= ret_cnt + 1'b1;
                    asm_q[int'(ret_cnt)*MEM_DW +: MEM_DW] <= m_rsp_rdata;
                end
            end
            if (m_rsp_valid && !rsp_expected) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_width_adapter.sv
// Directed bench for bus_width_adapter: a 64->16 two-port instance driven against a
// latency-programmable memory model, plus a 32->32 single-port instance stepped by hand.
module tb_bus_width_adapter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   p_req_valid, p_req_ready, p_req_we, p_rsp_valid;
    logic [63:0]  p_req_addr;
    logic [127:0] p_req_wdata;
    logic [63:0]  p_rsp_rdata;
    logic         m_req_valid, m_req_ready, m_req_we, m_rsp_valid, err;
    logic [31:0]  m_req_addr;
    logic [15:0]  m_req_wdata, m_rsp_rdata;

    logic         r1_p_req_valid, r1_p_req_ready, r1_p_req_we, r1_p_rsp_valid;
    logic [31:0]  r1_p_req_addr, r1_p_req_wdata, r1_p_rsp_rdata;
    logic         r1_m_req_valid, r1_m_req_ready, r1_m_req_we, r1_m_rsp_valid, r1_err;
    logic [31:0]  r1_m_req_addr, r1_m_req_wdata, r1_m_rsp_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bus_width_adapter #(.ADDR_W(32), .PROC_DW(64), .MEM_DW(16), .N_PORTS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_req_valid(p_req_valid), .p_req_ready(p_req_ready), .p_req_we(p_req_we),
        .p_req_addr(p_req_addr), .p_req_wdata(p_req_wdata),
        .p_rsp_valid(p_rsp_valid), .p_rsp_rdata(p_rsp_rdata),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .err(err)
    );

    bus_width_adapter #(.ADDR_W(32), .PROC_DW(32), .MEM_DW(32), .N_PORTS(1)) dut_r1 (
        .clk(clk), .rst_n(rst_n),
        .p_req_valid(r1_p_req_valid), .p_req_ready(r1_p_req_ready), .p_req_we(r1_p_req_we),
        .p_req_addr(r1_p_req_addr), .p_req_wdata(r1_p_req_wdata),
        .p_rsp_valid(r1_p_rsp_valid), .p_rsp_rdata(r1_p_rsp_rdata),
        .m_req_valid(r1_m_req_valid), .m_req_ready(r1_m_req_ready), .m_req_we(r1_m_req_we),
        .m_req_addr(r1_m_req_addr), .m_req_wdata(r1_m_req_wdata),
        .m_rsp_valid(r1_m_rsp_valid), .m_rsp_rdata(r1_m_rsp_rdata), .err(r1_err)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // memory model: programmable latency, optional 1,0,0 ready pattern, stray pulse injection
    int          lat = 3;
    int          ready_mode = 0;
    int          stray_req = 0;
    int          stray_done = 0;
    int          ready_idx = 0;
    int          ret_total = 0;
    int          stall_viol = 0;
    logic [15:0] rd_tab [4];
    int          due_q[$];
    logic [15:0] dat_q[$];
    logic [31:0] beat_addr_q[$];
    logic [15:0] beat_data_q[$];
    logic        beat_we_q[$];
    int          beat_cyc_q[$];
    logic        stalled_prev = 1'b0;
    logic [31:0] prev_addr;
    logic [15:0] prev_data;
    logic        prev_we;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            due_q.delete();
            dat_q.delete();
            m_rsp_valid  = 1'b0;
            m_rsp_rdata  = '0;
            m_req_ready  = 1'b1;
            stalled_prev = 1'b0;
        end else begin
            m_req_ready = (ready_mode == 0) ? 1'b1 : (ready_idx % 3 == 0);
            ready_idx++;
            if (stalled_prev && (!m_req_valid || m_req_addr != prev_addr ||
                                 m_req_wdata != prev_data || m_req_we != prev_we))
                stall_viol++;
            if (m_req_valid && m_req_ready) begin
                beat_addr_q.push_back(m_req_addr);
                beat_data_q.push_back(m_req_wdata);
                beat_we_q.push_back(m_req_we);
                beat_cyc_q.push_back(cyc);
                if (!m_req_we) begin
                    due_q.push_back(cyc + lat);
                    dat_q.push_back(rd_tab[m_req_addr[2:1]]);
                end
            end
            stalled_prev = m_req_valid && !m_req_ready;
            prev_addr    = m_req_addr;
            prev_data    = m_req_wdata;
            prev_we      = m_req_we;
            m_rsp_valid  = 1'b0;
            m_rsp_rdata  = '0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                m_rsp_valid = 1'b1;
                m_rsp_rdata = dat_q.pop_front();
                void'(due_q.pop_front());
                ret_total++;
            end else if (stray_done < stray_req) begin
                m_rsp_valid = 1'b1;
                m_rsp_rdata = 16'hEEEE;
                stray_done++;
            end
        end
    end

    // response / grant monitor, sampled on the falling edge
    int          rsp_cyc_q[$];
    logic [1:0]  rsp_vec_q[$];
    logic [63:0] rsp_dat_q[$];
    int          gnt_cyc_q[$];
    int          gnt_port_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (p_rsp_valid != 2'b00) begin
                rsp_cyc_q.push_back(cyc);
                rsp_vec_q.push_back(p_rsp_valid);
                rsp_dat_q.push_back(p_rsp_rdata);
            end
            if ((p_req_valid & p_req_ready) != 2'b00) begin
                gnt_cyc_q.push_back(cyc);
                gnt_port_q.push_back(p_req_ready[1] ? 1 : 0);
            end
        end
    end

    // scoreboard check
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic wait_gnt(input int n);
        int t = 0;
        while (gnt_cyc_q.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("grant_wait", 64'(gnt_cyc_q.size() >= n), 64'd1);
    endtask

    task automatic wait_rsp(input int n);
        int t = 0;
        while (rsp_cyc_q.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("rsp_wait", 64'(rsp_cyc_q.size() >= n), 64'd1);
    endtask

    task automatic issue(input int port, input logic we, input logic [31:0] addr,
                         input logic [63:0] wd, output int t_hs);
        int n;
        n = gnt_cyc_q.size();
        @(posedge clk); #1;
        p_req_valid[port]         = 1'b1;
        p_req_we[port]            = we;
        p_req_addr[port*32 +: 32] = addr;
        p_req_wdata[port*64 +: 64] = wd;
        wait_gnt(n + 1);
        t_hs = (gnt_cyc_q.size() > n) ? gnt_cyc_q[n] : -1000;
        if (gnt_port_q.size() > n) check("grant_port", 64'(gnt_port_q[n]), 64'(port));
        @(posedge clk); #1;
        p_req_valid[port] = 1'b0;
    endtask

    task automatic check_beats(input string tag, input int b0, input logic [31:0] a0,
                               input logic [63:0] wd, input logic we, input int t0);
        check({tag, "_beat_count"}, 64'(beat_addr_q.size() - b0), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (b0 + k < beat_addr_q.size()) begin
                check($sformatf("%s_addr%0d", tag, k), 64'(beat_addr_q[b0+k]), 64'(a0 + 32'(2*k)));
                check($sformatf("%s_we%0d", tag, k), 64'(beat_we_q[b0+k]), 64'(we));
                if (we) check($sformatf("%s_data%0d", tag, k), 64'(beat_data_q[b0+k]), 64'(wd[k*16 +: 16]));
                if (t0 >= 0) check($sformatf("%s_cyc%0d", tag, k), 64'(beat_cyc_q[b0+k]), 64'(t0 + 1 + k));
            end
        end
    endtask

    initial begin
        int t, b0, m0, n0, r0, s0;
        rst_n          = 1'b0;
        p_req_valid    = '0;
        p_req_we       = '0;
        p_req_addr     = '0;
        p_req_wdata    = '0;
        r1_p_req_valid = 1'b0;
        r1_p_req_we    = 1'b0;
        r1_p_req_addr  = '0;
        r1_p_req_wdata = '0;
        r1_m_req_ready = 1'b1;
        r1_m_rsp_valid = 1'b0;
        r1_m_rsp_rdata = '0;
        rd_tab[0] = 16'h0000; rd_tab[1] = 16'h0000; rd_tab[2] = 16'h0000; rd_tab[3] = 16'h0000;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_p_req_ready", 64'(p_req_ready), 64'd0);
        check("rst_p_rsp_valid", 64'(p_rsp_valid), 64'd0);
        check("rst_p_rsp_rdata", p_rsp_rdata, 64'd0);
        check("rst_m_req_valid", 64'(m_req_valid), 64'd0);
        check("rst_m_req_we", 64'(m_req_we), 64'd0);
        check("rst_m_req_addr", 64'(m_req_addr), 64'd0);
        check("rst_m_req_wdata", 64'(m_req_wdata), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single write on port 0, memory always ready
        b0 = beat_addr_q.size(); m0 = rsp_cyc_q.size();
        issue(0, 1'b1, 32'h100, 64'h4444_3333_2222_1111, t);
        wait_rsp(m0 + 1);
        check_beats("wr0", b0, 32'h100, 64'h4444_3333_2222_1111, 1'b1, t);
        if (rsp_cyc_q.size() > m0) begin
            check("wr0_rsp_cyc", 64'(rsp_cyc_q[m0]), 64'(t + 5));
            check("wr0_rsp_vec", 64'(rsp_vec_q[m0]), 64'd1);
            check("wr0_rsp_data", rsp_dat_q[m0], 64'd0);
        end

        // read with zero latency: return lands in the same cycle as its beat
        lat = 0;
        rd_tab[0] = 16'h1234; rd_tab[1] = 16'h5678; rd_tab[2] = 16'h9ABC; rd_tab[3] = 16'hDEF0;
        b0 = beat_addr_q.size(); m0 = rsp_cyc_q.size();
        issue(0, 1'b0, 32'h300, 64'd0, t);
        wait_rsp(m0 + 1);
        check_beats("rd_l0", b0, 32'h300, 64'd0, 1'b0, t);
        if (rsp_cyc_q.size() > m0) begin
            check("rd_l0_rsp_cyc", 64'(rsp_cyc_q[m0]), 64'(t + 5));
            check("rd_l0_rsp_data", rsp_dat_q[m0], 64'hDEF0_9ABC_5678_1234);
        end
        check("rd_l0_err", 64'(err), 64'd0);

        // read on port 1 with latency 3
        lat = 3;
        rd_tab[0] = 16'hAAAA; rd_tab[1] = 16'hBBBB; rd_tab[2] = 16'hCCCC; rd_tab[3] = 16'hDDDD;
        m0 = rsp_cyc_q.size();
        issue(1, 1'b0, 32'h200, 64'd0, t);
        wait_rsp(m0 + 1);
        if (rsp_cyc_q.size() > m0) begin
            check("rd_l3_rsp_cyc", 64'(rsp_cyc_q[m0]), 64'(t + 8));
            check("rd_l3_rsp_vec", 64'(rsp_vec_q[m0]), 64'd2);
            check("rd_l3_rsp_data", rsp_dat_q[m0], 64'hDDDD_CCCC_BBBB_AAAA);
        end
        check("rd_l3_err", 64'(err), 64'd0);

        // both ports continuously valid for six writes
        n0 = gnt_cyc_q.size(); m0 = rsp_cyc_q.size();
        @(posedge clk); #1;
        p_req_we = 2'b11;
        p_req_addr = {32'h500, 32'h400};
        p_req_wdata = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        p_req_valid = 2'b11;
        wait_gnt(n0 + 6);
        @(posedge clk); #1;
        p_req_valid = 2'b00;
        wait_rsp(m0 + 6);
        for (int i = 0; i < 6; i++) begin
            if (gnt_port_q.size() > n0 + i)
                check($sformatf("rr_grant%0d", i), 64'(gnt_port_q[n0+i]), 64'(i % 2));
            if (i > 0 && gnt_cyc_q.size() > n0 + i)
                check($sformatf("rr_gap%0d", i), 64'(gnt_cyc_q[n0+i] - gnt_cyc_q[n0+i-1]), 64'd6);
            if (rsp_vec_q.size() > m0 + i)
                check($sformatf("rr_rsp%0d", i), 64'(rsp_vec_q[m0+i]), (i % 2 == 1) ? 64'd2 : 64'd1);
        end

        // stalled write from a misaligned address
        ready_mode = 1;
        b0 = beat_addr_q.size(); m0 = rsp_cyc_q.size();
        issue(0, 1'b1, 32'h103, 64'h8888_7777_6666_5555, t);
        wait_rsp(m0 + 1);
        check_beats("stall", b0, 32'h100, 64'h8888_7777_6666_5555, 1'b1, -1);
        check("stall_stable", 64'(stall_viol), 64'd0);
        ready_mode = 0;

        // reset in the middle of a read, then stray returns
        m0 = rsp_cyc_q.size(); r0 = ret_total;
        issue(0, 1'b0, 32'h600, 64'd0, t);
        s0 = 0;
        while (ret_total < r0 + 2 && s0 < 100) begin
            @(negedge clk);
            s0++;
        end
        check("midrst_two_returns", 64'(ret_total >= r0 + 2), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_m_req_valid", 64'(m_req_valid), 64'd0);
        check("midrst_p_rsp_valid", 64'(p_rsp_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_err_clear", 64'(err), 64'd0);
        stray_req = stray_req + 2;
        repeat (5) @(negedge clk);
        check("stray_err", 64'(err), 64'd1);
        check("midrst_no_rsp", 64'(rsp_cyc_q.size()), 64'(m0));

        // single-beat instance: read with latency 2 from a misaligned address
        @(posedge clk); #1;
        r1_p_req_valid = 1'b1;
        r1_p_req_we    = 1'b0;
        r1_p_req_addr  = 32'h43;
        @(negedge clk);
        check("r1_ready", 64'(r1_p_req_ready), 64'd1);
        @(posedge clk); #1;
        r1_p_req_valid = 1'b0;
        @(negedge clk);
        check("r1_beat_valid", 64'(r1_m_req_valid), 64'd1);
        check("r1_beat_addr", 64'(r1_m_req_addr), 64'h40);
        check("r1_beat_we", 64'(r1_m_req_we), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("r1_beat_once", 64'(r1_m_req_valid), 64'd0);
        @(posedge clk); #1;
        r1_m_rsp_valid = 1'b1;
        r1_m_rsp_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("r1_rsp_early", 64'(r1_p_rsp_valid), 64'd0);
        @(posedge clk); #1;
        r1_m_rsp_valid = 1'b0;
        r1_m_rsp_rdata = '0;
        @(negedge clk);
        check("r1_rsp_valid", 64'(r1_p_rsp_valid), 64'd1);
        check("r1_rsp_data", 64'(r1_p_rsp_rdata), 64'hCAFE_F00D);
        @(negedge clk);
        check("r1_rsp_pulse", 64'(r1_p_rsp_valid), 64'd0);
        check("r1_err", 64'(r1_err), 64'd0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
